decode_dispatch: RTL and testbench
==================================

# decode_dispatch

Issue stage that consumes the 15-bit decode word from the instruction decoder and routes each instruction to the ALU, load/store or CSR unit over per-unit valid/ready handshakes. It sits between the decoder and the execution units. It holds one instruction in an issue register, drains outstanding memory operations on FENCE, and raises a trap request for illegal, ECALL and EBREAK instructions. It sustains one dispatch per cycle when the target unit is ready.

## Interface
- XLEN, 32, PC width
- LS_MAX_OUT, 4, maximum load/store operations in flight (≥1)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  discards the held instruction (redirect or trap entry)
- in_valid_i / in_ready_o  in/out  1  decoder-side handshake
- in_decode_i  in  15  {unit[14:13], sub_unit[12:10], sel[9:6], imm[5], fence[4], ecall[3], ebreak[2], illegal[1], calc_j[0]}
- in_pc_i  in  XLEN  PC of the instruction
- in_instr_i  in  32  raw instruction, used for operand and immediate extraction
- alu_valid_o/alu_ready_i, ls_valid_o/ls_ready_i, csr_valid_o/csr_ready_i  out/in  1  per-unit handshakes
- op_sub_unit_o 3, op_sel_o 4, op_imm_o 1, op_calc_j_o 1, op_pc_o XLEN, op_instr_o 32  out  payload shared by all units, valid with any unit valid
- ls_done_i  in  1  one-cycle pulse per completed load/store
- trap_valid_o  out  1  trap request
- trap_cause_o  out  2  0 = illegal, 1 = ecall, 2 = ebreak
- trap_pc_o  out  XLEN  PC of the trapping instruction
- trap_ack_i  in  1  trap accepted
- fence_busy_o  out  1  high while in DRAIN
- perf_dispatch_o, perf_stall_o  out  32  performance counters (see Configuration)

## Operation
- FSM states:
  - EMPTY: issue register empty.
  - HOLD: valid entry waiting for its unit.
  - DRAIN: FENCE waiting for memory operations to complete.
  - TRAP: trap request outstanding.
- Capture: the decode word, PC and instruction are registered on in_valid_i && in_ready_o.
- Classification of the captured entry, highest priority first:
  1. illegal=1 or unit=3 → TRAP with cause 0.
  2. ecall → TRAP with cause 1.
  3. ebreak → TRAP with cause 2.
  4. fence → DRAIN.
  5. Otherwise HOLD, dispatching to unit 0 = ALU, 1 = LS, 2 = CSR.
- Exactly one of alu/ls/csr_valid_o is high in HOLD, and it stays high with a stable payload until that unit's ready is high.
- in_ready_o = (state == EMPTY) || (HOLD && the selected unit fires this cycle). It is combinational and is 0 in DRAIN and TRAP.
- Outstanding counter: width $clog2(LS_MAX_OUT+1).
  - +1 on an LS fire, −1 on ls_done_i.
  - Both in the same cycle leave it unchanged.
  - ls_done_i at zero is ignored (no underflow).
- When the counter equals LS_MAX_OUT, ls_valid_o is forced low and the entry stays held.
- DRAIN: leaves to EMPTY in the cycle after the counter reads 0. A FENCE retires without dispatching to any unit.
- TRAP: trap_valid_o stays high until trap_ack_i, then the entry clears and the FSM goes to EMPTY.
- flush_i:
  - Clears the entry and forces EMPTY, dropping any pending trap_valid_o.
  - flush_i takes precedence over a same-cycle capture or fire.
  - The outstanding counter is not cleared.

## Timing
- Reset (async assert, sync-released state):
  - State = EMPTY; counter = 0.
  - All valid, trap and fence_busy outputs = 0; payload = 0; perf counters = 0.
  - in_ready_o = 1.
- Latency:
  - Accept in cycle N → unit valid in cycle N+1.
  - Back-to-back accept/fire gives 1 instruction per cycle.
- Trap: trap_valid_o rises the cycle after capture. Minimum 2 cycles from capture to the next accept (ack in the first cycle).
- FENCE with counter 0 at capture: DRAIN for 1 cycle, next accept at N+2.
- All outputs except in_ready_o are registered.

## Configuration
- DISPATCH_PERF_EN defined:
  - perf_dispatch_o counts unit fires.
  - perf_stall_o counts cycles with the entry held in HOLD while the target unit is not ready.
  - Both are 32-bit and wrap at 2^32.
  - Both are cleared by reset only, not by flush_i.
- DISPATCH_PERF_EN undefined: both outputs tied to 0 and no counter flops are present.

## Test plan
- ADD (unit 0, sub 2, sel 0) with alu_ready_i=1 → alu_valid_o high 1 cycle after accept, op_sub_unit_o=2, op_sel_o=0; 4 back-to-back ADDs → 4 fires in 4 consecutive cycles.
- Five LWs with ls_ready_i=1 and no ls_done_i, LS_MAX_OUT=4 → 4 fires, then ls_valid_o=0 and in_ready_o=0; one ls_done_i pulse → the 5th fires the next cycle.
- FENCE with 2 loads outstanding → fence_busy_o high until the 2nd ls_done_i, EMPTY the following cycle, no unit valid asserted.
- Decode word with illegal=1 and ecall=1 at PC 0x100 → trap_valid_o, trap_cause_o=0, trap_pc_o=0x100; held 3 cycles until trap_ack_i, then in_ready_o=1.
- CSR entry held with csr_ready_i=0 plus flush_i → csr_valid_o=0 next cycle, state EMPTY, counter unchanged.
- rst_n asserted mid-DRAIN → all outputs at their reset values immediately, in_ready_o=1 after release; with DISPATCH_PERF_EN defined, perf_dispatch_o=0.

Source files
------------

// File: rtl/decode_dispatch.sv
// decode_dispatch: one-entry issue register that routes decoded instructions to ALU/LS/CSR, drains on FENCE, raises traps.
// Latency: accept in cycle N -> unit valid in N+1; back-to-back accept/fire sustains one dispatch per cycle.
// Backpressure: in_ready_o drops while the entry waits for its unit, in DRAIN and TRAP; LS is held when LS_MAX_OUT ops are in flight.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   flush_i                          drop the held entry (redirect / trap entry)
//   in_valid_i/in_ready_o            decoder handshake; in_decode_i, in_pc_i, in_instr_i are the payload
//   {alu,ls,csr}_valid_o/_ready_i    per-unit handshakes; op_* payload is shared by all units
//   ls_done_i                        one pulse per completed load/store
//   trap_valid_o/trap_ack_i          trap request with trap_cause_o (0 illegal, 1 ecall, 2 ebreak) and trap_pc_o
//   fence_busy_o                     high while a FENCE waits for memory ops to complete
//   perf_dispatch_o, perf_stall_o    counters, present only when DISPATCH_PERF_EN is defined (otherwise 0)
module decode_dispatch #(
    parameter int XLEN       = 32,
    parameter int LS_MAX_OUT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [14:0]     in_decode_i,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [31:0]     in_instr_i,
    output logic            alu_valid_o,
    input  logic            alu_ready_i,
    output logic            ls_valid_o,
    input  logic            ls_ready_i,
    output logic            csr_valid_o,
    input  logic            csr_ready_i,
    output logic [2:0]      op_sub_unit_o,
    output logic [3:0]      op_sel_o,
    output logic            op_imm_o,
    output logic            op_calc_j_o,
    output logic [XLEN-1:0] op_pc_o,
    output logic [31:0]     op_instr_o,
    input  logic            ls_done_i,
    output logic            trap_valid_o,
    output logic [1:0]      trap_cause_o,
    output logic [XLEN-1:0] trap_pc_o,
    input  logic            trap_ack_i,
    output logic            fence_busy_o,
    output logic [31:0]     perf_dispatch_o,
    output logic [31:0]     perf_stall_o
);
    localparam int CW = $clog2(LS_MAX_OUT + 1);

    typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_DRAIN, ST_TRAP} state_t;

    typedef struct packed {
        logic [1:0]      unit;
        logic [2:0]      sub_unit;
        logic [3:0]      sel;
        logic            imm;
        logic            calc_j;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    state_t        state_q, state_d;
    entry_t        ent_q;
    logic [1:0]    cause_q;
    logic [CW-1:0] out_cnt_q;

    state_t        cap_state;
    logic [1:0]    cap_cause;
    logic          ls_full;
    logic          sel_vld, sel_rdy;
    logic          unit_fire, fire_eff, capture;
    logic          ls_inc, ls_dec;

    // Unit valids decode straight from flops, so no input-to-output path exists on them.
    assign ls_full     = (out_cnt_q == CW'(LS_MAX_OUT));
    assign alu_valid_o = (state_q == ST_HOLD) && (ent_q.unit == 2'd0);
    assign ls_valid_o  = (state_q == ST_HOLD) && (ent_q.unit == 2'd1) && !ls_full;
    assign csr_valid_o = (state_q == ST_HOLD) && (ent_q.unit == 2'd2);
    assign sel_vld     = alu_valid_o || ls_valid_o || csr_valid_o;

    always_comb begin
        sel_rdy = 1'b0;
        case (ent_q.unit)
            2'd0:    sel_rdy = alu_ready_i;
            2'd1:    sel_rdy = ls_ready_i;
            2'd2:    sel_rdy = csr_ready_i;
            default: sel_rdy = 1'b0;
        endcase
    end

    assign unit_fire  = sel_vld && sel_rdy;
    assign in_ready_o = (state_q == ST_EMPTY) || unit_fire;
    // A flush wins over both the capture and the fire in the same cycle.
    assign capture    = in_valid_i && in_ready_o && !flush_i;
    assign fire_eff   = unit_fire && !flush_i;

    // Classify the incoming word; the first matching rule decides where the entry goes.
    always_comb begin
        cap_state = ST_HOLD;
        cap_cause = 2'd0;
        if (in_decode_i[1] || (in_decode_i[14:13] == 2'd3)) begin
            cap_state = ST_TRAP;
            cap_cause = 2'd0;
        end else if (in_decode_i[3]) begin
            cap_state = ST_TRAP;
            cap_cause = 2'd1;
        end else if (in_decode_i[2]) begin
            cap_state = ST_TRAP;
            cap_cause = 2'd2;
        end else if (in_decode_i[4]) begin
            cap_state = ST_DRAIN;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (capture) state_d = cap_state;
            ST_HOLD:  if (fire_eff) state_d = capture ? cap_state : ST_EMPTY;
            // Leaves one cycle after the registered count reads zero.
            ST_DRAIN: if (out_cnt_q == '0) state_d = ST_EMPTY;
            ST_TRAP:  if (trap_ack_i) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (flush_i) state_d = ST_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ent_q   <= '0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                ent_q.unit     <= in_decode_i[14:13];
                ent_q.sub_unit <= in_decode_i[12:10];
                ent_q.sel      <= in_decode_i[9:6];
                ent_q.imm      <= in_decode_i[5];
                ent_q.calc_j   <= in_decode_i[0];
                ent_q.pc       <= in_pc_i;
                ent_q.instr    <= in_instr_i;
                cause_q        <= cap_cause;
            end else if (state_d == ST_EMPTY) begin
                ent_q   <= '0;
                cause_q <= 2'd0;
            end
        end
    end

    // In-flight load/store count; a done pulse with nothing outstanding is dropped. Flush leaves it alone.
    assign ls_inc = ls_valid_o && ls_ready_i && !flush_i;
    assign ls_dec = ls_done_i && (out_cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_q <= '0;
        end else if (ls_inc && !ls_dec) begin
            out_cnt_q <= out_cnt_q + CW'(1);
        end else if (!ls_inc && ls_dec) begin
            out_cnt_q <= out_cnt_q - CW'(1);
        end
    end

    assign op_sub_unit_o = ent_q.sub_unit;
    assign op_sel_o      = ent_q.sel;
    assign op_imm_o      = ent_q.imm;
    assign op_calc_j_o   = ent_q.calc_j;
    assign op_pc_o       = ent_q.pc;
    assign op_instr_o    = ent_q.instr;
    assign trap_valid_o  = (state_q == ST_TRAP);
    assign trap_cause_o  = cause_q;
    assign trap_pc_o     = ent_q.pc;
    assign fence_busy_o  = (state_q == ST_DRAIN);

`ifdef DISPATCH_PERF_EN
    logic [31:0] perf_dispatch_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_dispatch_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            if (fire_eff) perf_dispatch_q <= perf_dispatch_q + 32'd1;
            if ((state_q == ST_HOLD) && !sel_rdy) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_dispatch_o = perf_dispatch_q;
    assign perf_stall_o    = perf_stall_q;
`else
    assign perf_dispatch_o = 32'd0;
    assign perf_stall_o    = 32'd0;
`endif

endmodule

// File: tb/tb_decode_dispatch.sv
// tb_decode_dispatch: classification table, hand-written multi-cycle sequences, then random traffic against a model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_decode_dispatch;
    localparam int XLEN   = 32;
    localparam int LS_MAX = 4;
`ifdef DISPATCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0] F_IMM = 6'b100000, F_FENCE = 6'b010000, F_ECALL = 6'b001000;
    localparam logic [5:0] F_EBRK = 6'b000100, F_ILL = 6'b000010, F_CJ = 6'b000001;
    localparam int K_ALU = 0, K_LS = 1, K_CSR = 2, K_FENCE = 3, K_TRAP = 4, K_NONE = 7;

    logic            clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0;
    logic            in_valid_i = 1'b0, in_ready_o;
    logic [14:0]     in_decode_i = '0;
    logic [XLEN-1:0] in_pc_i = '0;
    logic [31:0]     in_instr_i = '0;
    logic            alu_valid_o, ls_valid_o, csr_valid_o;
    logic            alu_ready_i = 1'b0, ls_ready_i = 1'b0, csr_ready_i = 1'b0;
    logic [2:0]      op_sub_unit_o;
    logic [3:0]      op_sel_o;
    logic            op_imm_o, op_calc_j_o;
    logic [XLEN-1:0] op_pc_o, trap_pc_o;
    logic [31:0]     op_instr_o, perf_dispatch_o, perf_stall_o;
    logic            ls_done_i = 1'b0, trap_valid_o, trap_ack_i = 1'b0, fence_busy_o;
    logic [1:0]      trap_cause_o;

    decode_dispatch #(.XLEN(XLEN), .LS_MAX_OUT(LS_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_decode_i(in_decode_i),
        .in_pc_i(in_pc_i), .in_instr_i(in_instr_i),
        .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
        .ls_valid_o(ls_valid_o), .ls_ready_i(ls_ready_i),
        .csr_valid_o(csr_valid_o), .csr_ready_i(csr_ready_i),
        .op_sub_unit_o(op_sub_unit_o), .op_sel_o(op_sel_o), .op_imm_o(op_imm_o),
        .op_calc_j_o(op_calc_j_o), .op_pc_o(op_pc_o), .op_instr_o(op_instr_o),
        .ls_done_i(ls_done_i), .trap_valid_o(trap_valid_o), .trap_cause_o(trap_cause_o),
        .trap_pc_o(trap_pc_o), .trap_ack_i(trap_ack_i), .fence_busy_o(fence_busy_o),
        .perf_dispatch_o(perf_dispatch_o), .perf_stall_o(perf_stall_o)
    );

    always #5 clk = ~clk;

    // {alu, ls, csr, trap, fence_busy}
    wire [4:0] vis = {alu_valid_o, ls_valid_o, csr_valid_o, trap_valid_o, fence_busy_o};
    wire [8:0] pay = {op_sub_unit_o, op_sel_o, op_imm_o, op_calc_j_o};

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] mkdec(input logic [1:0] unit, input logic [2:0] sub,
                                          input logic [3:0] sel, input logic [5:0] fl);
        return {unit, sub, sel, fl};
    endfunction

    // Classification rules in priority order.
    function automatic void classify(input logic [14:0] d, output int kind, output logic [1:0] cause);
        cause = 2'd0;
        if (d[1] || d[14:13] == 2'd3) kind = K_TRAP;
        else if (d[3]) begin kind = K_TRAP; cause = 2'd1; end
        else if (d[2]) begin kind = K_TRAP; cause = 2'd2; end
        else if (d[4]) kind = K_FENCE;
        else kind = int'(d[14:13]);
    endfunction

    typedef struct {
        logic [14:0] dec;
        logic [31:0] pc;
        logic [4:0]  exp_vis;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t tbl[11];

    // Random-phase reference state.
    int          m_kind, m_out;
    logic [1:0]  m_cause;
    logic [8:0]  m_pay;
    logic [31:0] m_pc, m_instr, m_pd, m_ps;

    initial begin
        logic [14:0] add_w, lw_w, csr_w, fence_w, d;
        int n_fire, acc, kind, r;
        logic [1:0] cz;
        bit e_alu, e_ls, e_csr, e_fire, e_rdy, cap;

        add_w   = mkdec(2'd0, 3'd2, 4'd0, 6'd0);
        lw_w    = mkdec(2'd1, 3'd0, 4'd2, F_IMM);
        csr_w   = mkdec(2'd2, 3'd1, 4'd3, 6'd0);
        fence_w = mkdec(2'd0, 3'd0, 4'd0, F_FENCE);

        tbl[0]  = '{add_w,                                      32'h1000, 5'b10000, 2'd0};
        tbl[1]  = '{lw_w,                                       32'h1004, 5'b01000, 2'd0};
        tbl[2]  = '{csr_w,                                      32'h1008, 5'b00100, 2'd0};
        tbl[3]  = '{fence_w,                                    32'h100c, 5'b00001, 2'd0};
        tbl[4]  = '{mkdec(2'd0, 3'd0, 4'd0, F_ILL | F_ECALL),   32'h1010, 5'b00010, 2'd0};
        tbl[5]  = '{mkdec(2'd3, 3'd4, 4'd5, 6'd0),              32'h1014, 5'b00010, 2'd0};
        tbl[6]  = '{mkdec(2'd2, 3'd0, 4'd0, F_ECALL),           32'h1018, 5'b00010, 2'd1};
        tbl[7]  = '{mkdec(2'd1, 3'd0, 4'd0, F_EBRK),            32'h101c, 5'b00010, 2'd2};
        tbl[8]  = '{mkdec(2'd0, 3'd0, 4'd0, F_ECALL | F_EBRK),  32'h1020, 5'b00010, 2'd1};
        tbl[9]  = '{mkdec(2'd0, 3'd0, 4'd0, F_FENCE | F_EBRK),  32'h1024, 5'b00010, 2'd2};
        tbl[10] = '{mkdec(2'd0, 3'd5, 4'd9, F_IMM | F_CJ),      32'h1028, 5'b10000, 2'd0};

        // Reset state.
        #2;
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_vis", vis, 5'b0);
        chk("rst_payload", {pay, op_pc_o, op_instr_o}, '0);
        chk("rst_trap_info", {trap_cause_o, trap_pc_o}, '0);
        chk("rst_perf", {perf_dispatch_o, perf_stall_o}, '0);
        #10 rst_n = 1'b1;

        // Classification table: capture, inspect held entry, flush it away.
        foreach (tbl[i]) begin
            tick();
            in_valid_i = 1'b1; in_decode_i = tbl[i].dec; in_pc_i = tbl[i].pc; in_instr_i = $urandom;
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready_o, 1'b1);
            tick();
            in_valid_i = 1'b0;
            #1;
            chk($sformatf("vec%0d_vis", i), vis, tbl[i].exp_vis);
            chk($sformatf("vec%0d_held_ready", i), in_ready_o, 1'b0);
            if (tbl[i].exp_vis[1])
                chk($sformatf("vec%0d_trap", i), {trap_cause_o, trap_pc_o}, {tbl[i].exp_cause, tbl[i].pc});
            if (tbl[i].exp_vis[4:2] != 3'b000)
                chk($sformatf("vec%0d_payload", i), {pay, op_pc_o},
                    {tbl[i].dec[12:10], tbl[i].dec[9:6], tbl[i].dec[5], tbl[i].dec[0], tbl[i].pc});
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
            #1;
            chk($sformatf("vec%0d_flushed", i), {vis, in_ready_o}, 6'b000001);
        end

        // Four back-to-back ADDs fire in four consecutive cycles.
        alu_ready_i = 1'b1;
        n_fire = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            in_valid_i = (c < 4); in_decode_i = add_w;
            #1;
            if (c >= 1 && c <= 4) chk($sformatf("add_b2b_valid_c%0d", c), alu_valid_o, 1'b1);
            if (c == 1) chk("add_payload", {op_sub_unit_o, op_sel_o}, {3'd2, 4'd0});
            if (alu_valid_o && alu_ready_i) n_fire++;
        end
        chk("add_b2b_after", alu_valid_o, 1'b0);
        chk("add_b2b_fires", n_fire, 4);
        alu_ready_i = 1'b0;

        // Five LWs with no completions: four fire, the fifth waits for a done pulse.
        ls_ready_i = 1'b1;
        acc = 0; n_fire = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            in_valid_i = (acc < 5); in_decode_i = lw_w;
            #1;
            if (in_valid_i && in_ready_o) acc++;
            if (ls_valid_o && ls_ready_i) n_fire++;
        end
        chk("lw_fires_at_limit", n_fire, 4);
        chk("lw_limit_block", {ls_valid_o, in_ready_o}, 2'b00);
        tick(); ls_done_i = 1'b1; #1;
        chk("lw_done_cycle", ls_valid_o, 1'b0);
        tick(); ls_done_i = 1'b0; #1;
        chk("lw_fifth_fires", ls_valid_o, 1'b1);
        tick(); #1;
        chk("lw_after_fifth", {ls_valid_o, in_ready_o}, 2'b01);
        ls_ready_i = 1'b0;
        // Four in flight; retire two so two remain.
        tick(); ls_done_i = 1'b1;
        tick(); ls_done_i = 1'b1;
        tick(); ls_done_i = 1'b0;

        // CSR held without ready, then flushed.
        in_valid_i = 1'b1; in_decode_i = csr_w;
        tick(); in_valid_i = 1'b0; #1;
        chk("csr_held", vis, 5'b00100);
        flush_i = 1'b1;
        tick(); flush_i = 1'b0; #1;
        chk("csr_flushed", {vis, in_ready_o}, 6'b000001);

        // FENCE with two loads still outstanding (flush must not have cleared the count).
        tick(); in_valid_i = 1'b1; in_decode_i = fence_w; #1;
        tick(); in_valid_i = 1'b0; ls_done_i = 1'b1; #1;
        chk("fence_busy_f1", {vis, in_ready_o}, 6'b000010);
        tick(); ls_done_i = 1'b0; #1;
        chk("fence_busy_f2", vis, 5'b00001);
        tick(); ls_done_i = 1'b1; #1;
        chk("fence_busy_f3", vis, 5'b00001);
        tick(); ls_done_i = 1'b0; #1;
        chk("fence_busy_f4", vis, 5'b00001);
        tick(); #1;
        chk("fence_done", {vis, in_ready_o}, 6'b000001);

        // Illegal+ecall traps with cause 0, held until acknowledged.
        tick(); in_valid_i = 1'b1; in_decode_i = mkdec(2'd0, 3'd0, 4'd0, F_ILL | F_ECALL); in_pc_i = 32'h100; #1;
        tick(); in_valid_i = 1'b0; #1;
        chk("trap_t1", {trap_valid_o, trap_cause_o, trap_pc_o, in_ready_o}, {1'b1, 2'd0, 32'h100, 1'b0});
        tick(); #1;
        chk("trap_t2", trap_valid_o, 1'b1);
        tick(); trap_ack_i = 1'b1; #1;
        chk("trap_t3", trap_valid_o, 1'b1);
        tick(); trap_ack_i = 1'b0; #1;
        chk("trap_cleared", {trap_valid_o, in_ready_o}, 2'b01);

        // Reset while draining behind one outstanding load.
        tick(); in_valid_i = 1'b1; in_decode_i = lw_w; ls_ready_i = 1'b1; #1;
        tick(); in_decode_i = fence_w; #1;
        tick(); in_valid_i = 1'b0; ls_ready_i = 1'b0; #1;
        chk("pre_reset_drain", fence_busy_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_vis", vis, 5'b0);
        chk("async_rst_ready", in_ready_o, 1'b1);
        chk("async_rst_perf_dispatch", perf_dispatch_o, 32'd0);
        chk("async_rst_payload", {pay, op_pc_o}, '0);
        #3 rst_n = 1'b1;
        tick(); #1;
        chk("post_rst_idle", {vis, in_ready_o}, 6'b000001);

        // Random traffic against the reference model.
        m_kind = K_NONE; m_out = 0; m_cause = 0; m_pay = 0; m_pc = 0; m_instr = 0; m_pd = 0; m_ps = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            d = 15'($urandom);
            r = $urandom_range(0, 9);
            if (r < 7) d = mkdec(2'($urandom_range(0, 2)), d[12:10], d[9:6], {d[5], 4'b0000, d[0]});
            else if (r == 7) d = mkdec(d[14:13], d[12:10], d[9:6], {d[5], 1'b1, 3'b000, d[0]});
            in_decode_i = d;
            in_valid_i  = ($urandom_range(0, 9) < 7);
            in_pc_i     = $urandom;
            in_instr_i  = $urandom;
            alu_ready_i = ($urandom_range(0, 9) < 7);
            ls_ready_i  = ($urandom_range(0, 9) < 7);
            csr_ready_i = ($urandom_range(0, 9) < 6);
            ls_done_i   = ($urandom_range(0, 9) < 3);
            trap_ack_i  = ($urandom_range(0, 9) < 4);
            flush_i     = ($urandom_range(0, 99) < 3);
            #1;
            e_alu  = (m_kind == K_ALU);
            e_ls   = (m_kind == K_LS) && (m_out < LS_MAX);
            e_csr  = (m_kind == K_CSR);
            e_fire = (e_alu && alu_ready_i) || (e_ls && ls_ready_i) || (e_csr && csr_ready_i);
            e_rdy  = (m_kind == K_NONE) || e_fire;
            chk("rnd_vis", vis, {e_alu, e_ls, e_csr, m_kind == K_TRAP, m_kind == K_FENCE});
            chk("rnd_in_ready", in_ready_o, e_rdy);
            if (e_alu || e_ls || e_csr) chk("rnd_payload", {pay, op_pc_o, op_instr_o}, {m_pay, m_pc, m_instr});
            if (m_kind == K_TRAP) chk("rnd_trap", {trap_cause_o, trap_pc_o}, {m_cause, m_pc});
            chk("rnd_perf", {perf_dispatch_o, perf_stall_o}, PERF ? {m_pd, m_ps} : 64'd0);

            // Advance the model across the coming clock edge.
            cap = in_valid_i && e_rdy && !flush_i;
            if ((e_alu && !alu_ready_i) || (m_kind == K_LS && !ls_ready_i) || (e_csr && !csr_ready_i)) m_ps++;
            if (e_fire && !flush_i) m_pd++;
            if (flush_i) m_kind = K_NONE;
            else if (cap) begin
                classify(in_decode_i, kind, cz);
                m_kind = kind; m_cause = cz;
                m_pay = {in_decode_i[12:10], in_decode_i[9:6], in_decode_i[5], in_decode_i[0]};
                m_pc = in_pc_i; m_instr = in_instr_i;
            end
            else if (e_fire) m_kind = K_NONE;
            else if (m_kind == K_FENCE && m_out == 0) m_kind = K_NONE;
            else if (m_kind == K_TRAP && trap_ack_i) m_kind = K_NONE;
            if (e_ls && ls_ready_i && !flush_i) m_out++;
            if (ls_done_i && (m_out > (e_ls && ls_ready_i && !flush_i ? 1 : 0))) m_out--;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
